// File: rtl/JZJCoreFTypes.sv
// Shared types for the JZJCoreF control path: memory modes, funct3 and the
// load/store sequencer state and fault encodings.
package JZJCoreFTypes;

  typedef logic [2:0] Funct3_t;

  typedef enum logic [2:0] {
    NOP           = 3'd0,
    LOAD          = 3'd1,
    STORE_PRELOAD = 3'd2,
    STORE         = 3'd3
  } MemoryMode_t;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_LOAD,
    SEQ_PRELOAD,
    SEQ_STORE,
    SEQ_FAULT
  } SequencerState_t;

  typedef enum logic [1:0] {
    FAULT_NONE,
    FAULT_UNALIGNED,
    FAULT_ILLEGAL_FUNCT3
  } FaultCause_t;

  // lb, lh, lw, lbu, lhu
  function automatic logic isLegalLoad(input Funct3_t f);
    return (f == 3'b000) || (f == 3'b001) || (f == 3'b010) ||
           (f == 3'b100) || (f == 3'b101);
  endfunction

  // sb, sh, sw
  function automatic logic isLegalStore(input Funct3_t f);
    return (f == 3'b000) || (f == 3'b001) || (f == 3'b010);
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Enable-gated wrapping counter with synchronous active-low clear.
module retire_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (!reset)
      count <= '0;
    else if (enable)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/memory_access_sequencer.sv
// Sequences one load (LOAD) or store (STORE_PRELOAD then STORE) at a time
// toward the memory controller, blocking the write on an unaligned address.
module memory_access_sequencer
  import JZJCoreFTypes::*;
#(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     reqValid,
  input  logic                     reqIsStore,
  input  logic [2:0]               reqFunct3,
  output logic                     reqReady,
  output MemoryMode_t              memoryMode,
  output logic [2:0]               funct3,
  input  logic                     memoryUnalignedAccess,
  output logic                     done,
  output logic                     fault,
  output FaultCause_t              faultCause,
  output logic [COUNTER_WIDTH-1:0] loadsRetired,
  output logic [COUNTER_WIDTH-1:0] storesRetired
);

  SequencerState_t state;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= SEQ_IDLE;
      funct3     <= 3'b000;
      faultCause <= FAULT_NONE;
    end else begin
      unique case (state)
        SEQ_IDLE: begin
          if (reqValid) begin
            funct3 <= reqFunct3;
            if (reqIsStore && isLegalStore(reqFunct3))
              state <= SEQ_PRELOAD;
            else if (!reqIsStore && isLegalLoad(reqFunct3))
              state <= SEQ_LOAD;
            else begin
              state      <= SEQ_FAULT;
              faultCause <= FAULT_ILLEGAL_FUNCT3;
            end
          end
        end
        SEQ_LOAD, SEQ_PRELOAD: begin
          if (memoryUnalignedAccess) begin
            state      <= SEQ_FAULT;
            faultCause <= FAULT_UNALIGNED;
          end else begin
            state <= (state == SEQ_LOAD) ? SEQ_IDLE : SEQ_STORE;
          end
        end
        SEQ_STORE: state <= SEQ_IDLE;
        SEQ_FAULT: state <= SEQ_FAULT;
        default:   state <= SEQ_IDLE;
      endcase
    end
  end

  always_comb begin
    reqReady   = 1'b0;
    memoryMode = NOP;
    done       = 1'b0;
    fault      = 1'b0;
    unique case (state)
      SEQ_IDLE:    reqReady = 1'b1;
      SEQ_LOAD: begin
        memoryMode = LOAD;
        done       = !memoryUnalignedAccess;
      end
      SEQ_PRELOAD: memoryMode = STORE_PRELOAD;
      SEQ_STORE: begin
        memoryMode = STORE;
        done       = 1'b1;
      end
      SEQ_FAULT:   fault = 1'b1;
      default:     reqReady = 1'b0;
    endcase
    // A reset landing on the STORE cycle must never reach the memory as a write.
    if (!reset) begin
      memoryMode = NOP;
      done       = 1'b0;
    end
  end

  retire_counter #(.WIDTH(COUNTER_WIDTH)) u_loads (
    .clock  (clock),
    .reset  (reset),
    .enable (done && (state == SEQ_LOAD)),
    .count  (loadsRetired)
  );

  retire_counter #(.WIDTH(COUNTER_WIDTH)) u_stores (
    .clock  (clock),
    .reset  (reset),
    .enable (done && (state == SEQ_STORE)),
    .count  (storesRetired)
  );

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Scoreboard bench for memory_access_sequencer: each driven cycle queues the
// expected outputs; a negedge monitor pops and compares.
module tb_memory_access_sequencer;
  import JZJCoreFTypes::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqIsStore = 1'b0;
  logic [2:0]  reqFunct3 = 3'b000;
  logic        memoryUnalignedAccess = 1'b0;
  logic        reqReady;
  MemoryMode_t memoryMode;
  logic [2:0]  funct3;
  logic        done;
  logic        fault;
  FaultCause_t faultCause;
  logic [1:0]  loadsRetired;
  logic [1:0]  storesRetired;

  memory_access_sequencer #(.COUNTER_WIDTH(2)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .reqValid              (reqValid),
    .reqIsStore            (reqIsStore),
    .reqFunct3             (reqFunct3),
    .reqReady              (reqReady),
    .memoryMode            (memoryMode),
    .funct3                (funct3),
    .memoryUnalignedAccess (memoryUnalignedAccess),
    .done                  (done),
    .fault                 (fault),
    .faultCause            (faultCause),
    .loadsRetired          (loadsRetired),
    .storesRetired         (storesRetired)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] mode;
    logic       ready;
    logic       dn;
    logic       flt;
    logic [1:0] cause;
    logic [2:0] f3;
    logic [1:0] loads;
    logic [1:0] stores;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   tag = 0;

  always @(negedge clock) begin
    if (sbq.size() > 0) begin
      exp_t e;
      exp_t a;
      e = sbq.pop_front();
      a = '{mode: memoryMode, ready: reqReady, dn: done, flt: fault,
            cause: faultCause, f3: funct3, loads: loadsRetired, stores: storesRetired};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle%0d got mode=%0d ready=%0b done=%0b fault=%0b cause=%0d f3=%03b loads=%0d stores=%0d expected mode=%0d ready=%0b done=%0b fault=%0b cause=%0d f3=%03b loads=%0d stores=%0d",
                 tag, a.mode, a.ready, a.dn, a.flt, a.cause, a.f3, a.loads, a.stores,
                 e.mode, e.ready, e.dn, e.flt, e.cause, e.f3, e.loads, e.stores);
      end
      tag++;
    end
  end

  task automatic drive(input logic rst, input logic v, input logic s,
                       input logic [2:0] f, input logic ua);
    @(posedge clock);
    #1;
    reset = rst; reqValid = v; reqIsStore = s; reqFunct3 = f; memoryUnalignedAccess = ua;
  endtask

  task automatic expect_out(input MemoryMode_t m, input logic rdy, input logic dn,
                            input logic flt, input FaultCause_t c, input logic [2:0] f3,
                            input logic [1:0] l, input logic [1:0] s);
    sbq.push_back('{mode: m, ready: rdy, dn: dn, flt: flt, cause: c, f3: f3, loads: l, stores: s});
  endtask

  task automatic exp_idle(input logic [2:0] f3, input logic [1:0] l, input logic [1:0] s);
    expect_out(NOP, 1'b1, 1'b0, 1'b0, FAULT_NONE, f3, l, s);
  endtask

  task automatic exp_fault(input FaultCause_t c, input logic [2:0] f3,
                           input logic [1:0] l, input logic [1:0] s);
    expect_out(NOP, 1'b0, 1'b0, 1'b1, c, f3, l, s);
  endtask

  logic [1:0] wrap_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [2:0] load_f3  [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    // reset state
    drive(0, 0, 0, 3'b000, 0); exp_idle(3'b000, 0, 0);
    // lw, aligned
    drive(1, 1, 0, 3'b010, 0); exp_idle(3'b000, 0, 0);
    drive(1, 0, 0, 3'b000, 0); expect_out(LOAD, 0, 1, 0, FAULT_NONE, 3'b010, 0, 0);
    drive(1, 0, 0, 3'b000, 0); exp_idle(3'b010, 1, 0);
    // sb; request inputs change after accept and must be ignored
    drive(1, 1, 1, 3'b000, 0); exp_idle(3'b010, 1, 0);
    drive(1, 0, 0, 3'b111, 0); expect_out(STORE_PRELOAD, 0, 0, 0, FAULT_NONE, 3'b000, 1, 0);
    drive(1, 0, 0, 3'b111, 0); expect_out(STORE, 0, 1, 0, FAULT_NONE, 3'b000, 1, 0);
    drive(1, 0, 0, 3'b000, 0); exp_idle(3'b000, 1, 1);
    // illegal load funct3 011, then further requests ignored
    drive(1, 1, 0, 3'b011, 0); exp_idle(3'b000, 1, 1);
    drive(1, 0, 0, 3'b000, 0); exp_fault(FAULT_ILLEGAL_FUNCT3, 3'b011, 1, 1);
    drive(1, 1, 0, 3'b010, 0); exp_fault(FAULT_ILLEGAL_FUNCT3, 3'b011, 1, 1);
    drive(1, 0, 0, 3'b000, 0); exp_fault(FAULT_ILLEGAL_FUNCT3, 3'b011, 1, 1);
    drive(0, 0, 0, 3'b000, 0); exp_fault(FAULT_ILLEGAL_FUNCT3, 3'b011, 1, 1);
    drive(1, 0, 0, 3'b000, 0); exp_idle(3'b000, 0, 0);
    // unaligned sw: no STORE cycle
    drive(1, 1, 1, 3'b010, 0); exp_idle(3'b000, 0, 0);
    drive(1, 0, 0, 3'b000, 1); expect_out(STORE_PRELOAD, 0, 0, 0, FAULT_NONE, 3'b010, 0, 0);
    drive(1, 1, 1, 3'b000, 0); exp_fault(FAULT_UNALIGNED, 3'b010, 0, 0);
    drive(1, 0, 0, 3'b000, 0); exp_fault(FAULT_UNALIGNED, 3'b010, 0, 0);
    drive(0, 0, 0, 3'b000, 0); exp_fault(FAULT_UNALIGNED, 3'b010, 0, 0);
    drive(1, 0, 0, 3'b000, 0); exp_idle(3'b000, 0, 0);
    // unaligned lhu: no done
    drive(1, 1, 0, 3'b101, 0); exp_idle(3'b000, 0, 0);
    drive(1, 0, 0, 3'b000, 1); expect_out(LOAD, 0, 0, 0, FAULT_NONE, 3'b101, 0, 0);
    drive(1, 0, 0, 3'b000, 0); exp_fault(FAULT_UNALIGNED, 3'b101, 0, 0);
    drive(0, 0, 0, 3'b000, 0); exp_fault(FAULT_UNALIGNED, 3'b101, 0, 0);
    drive(1, 0, 0, 3'b000, 0); exp_idle(3'b000, 0, 0);
    // reset asserted in the STORE cycle of an sh
    drive(1, 1, 1, 3'b001, 0); exp_idle(3'b000, 0, 0);
    drive(1, 0, 0, 3'b000, 0); expect_out(STORE_PRELOAD, 0, 0, 0, FAULT_NONE, 3'b001, 0, 0);
    drive(0, 0, 0, 3'b000, 0); expect_out(NOP, 0, 0, 0, FAULT_NONE, 3'b001, 0, 0);
    drive(1, 0, 0, 3'b000, 0); exp_idle(3'b000, 0, 0);
    // five loads on a 2-bit counter: 1, 2, 3, 0, 1
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 0, load_f3[k], 0);
      exp_idle((k == 0) ? 3'b000 : load_f3[k-1], (k == 0) ? 2'd0 : wrap_seq[k-1], 0);
      drive(1, 0, 0, 3'b000, 0);
      expect_out(LOAD, 0, 1, 0, FAULT_NONE, load_f3[k], (k == 0) ? 2'd0 : wrap_seq[k-1], 0);
    end
    drive(1, 0, 0, 3'b000, 0); exp_idle(3'b101, 1, 0);
    // illegal store funct3 100
    drive(1, 1, 1, 3'b100, 0); exp_idle(3'b101, 1, 0);
    drive(1, 0, 0, 3'b000, 0); exp_fault(FAULT_ILLEGAL_FUNCT3, 3'b100, 1, 0);

    for (int w = 0; w < 20 && sbq.size() > 0; w++) @(posedge clock);
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0 pending", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access_sequencer.md
# memory_access_sequencer

Control-side stage directly upstream of the memory controller. It accepts one load or store request at a time from the decode/control unit and drives `memoryMode`/`funct3` cycle by cycle: a single LOAD cycle for loads, and a STORE_PRELOAD→STORE pair for every store. It watches the controller's `memoryUnalignedAccess` flag and blocks the write on a fault. It also reports completion, latches faults, and keeps retired-access counters.

## Interface
Parameters:
- `COUNTER_WIDTH`, 32, width of the retired load and store counters.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `reqValid`  in  1  request present; sampled only while `reqReady`=1.
- `reqIsStore`  in  1  1 = store, 0 = load.
- `reqFunct3`  in  3  instruction funct3.
- `reqReady`  out  1  sequencer can accept a request this cycle.
- `memoryMode`  out  MemoryMode_t  mode driven to the memory controller.
- `funct3`  out  3  latched funct3 driven to the memory controller.
- `memoryUnalignedAccess`  in  1  unaligned flag from the memory controller, same cycle.
- `done`  out  1  one-cycle pulse; the access completed without fault.
- `fault`  out  1  sticky fault flag.
- `faultCause`  out  FaultCause_t  NONE / UNALIGNED / ILLEGAL_FUNCT3.
- `loadsRetired`  out  COUNTER_WIDTH  count of completed loads.
- `storesRetired`  out  COUNTER_WIDTH  count of completed stores.

## Operation
States: IDLE, LOAD, PRELOAD, STORE, FAULT.

- **IDLE**
  - `reqReady`=1, `memoryMode`=NOP.
  - On `reqValid`, latch `reqFunct3` into the `funct3` register, then select the next state:
    - Load with funct3 ∈ {000,001,010,100,101} → LOAD.
    - Store with funct3 ∈ {000,001,010} → PRELOAD.
    - Any other funct3 → FAULT with cause ILLEGAL_FUNCT3. No memory cycle is issued.
- **LOAD**
  - `memoryMode`=LOAD.
  - If `memoryUnalignedAccess`=1 → FAULT with cause UNALIGNED.
  - Otherwise `done`=1, `loadsRetired`++, → IDLE.
- **PRELOAD**
  - `memoryMode`=STORE_PRELOAD.
  - Used for all store widths, including sw. This cycle is where alignment is checked, so the write-enabled STORE cycle is never issued for a bad address.
  - If `memoryUnalignedAccess`=1 → FAULT with cause UNALIGNED.
  - Otherwise → STORE.
- **STORE**
  - `memoryMode`=STORE.
  - `done`=1, `storesRetired`++, → IDLE.
  - `memoryUnalignedAccess` is ignored here; it cannot change because the address was already checked in PRELOAD.
- **FAULT**
  - `memoryMode`=NOP, `reqReady`=0, `fault`=1.
  - Held until reset.

Outputs are decoded from state: `reqReady`, `memoryMode`, `done`, `fault`. `done` additionally depends on `memoryUnalignedAccess` in LOAD.

Counters wrap modulo 2^COUNTER_WIDTH.

## Timing
- Reset (`reset`=0 at a clock edge):
  - State = IDLE, `funct3`=000, `fault`=0, `faultCause`=NONE, both counters 0.
  - While `reset`=0, `memoryMode` is forced to NOP combinationally. A reset that coincides with the STORE state never produces a write.
- Latency from the accept edge:
  - Load: done 1 cycle later.
  - Store: done 2 cycles later.
  - Next accept possible in the cycle after `done`. There are no back-to-back accepts.
- `reqIsStore` and `reqFunct3` are sampled only on the accept edge; later changes are ignored.
- `funct3` is stable from the cycle after accept until the next accept.
- Counter values update on the edge that ends the `done` cycle.
- Reset mid-operation: any state returns to IDLE on the next edge. An in-flight access produces no `done` and no counter increment.

## Structure
- Add `SequencerState_t` (IDLE, LOAD, PRELOAD, STORE, FAULT) and `FaultCause_t` (2-bit: NONE, UNALIGNED, ILLEGAL_FUNCT3) to `JZJCoreFTypes`. `MemoryMode_t` and `Funct3_t` are reused from that package.
- One sub-module, `retire_counter`: a parameterised-width, enable-gated, wrapping counter with synchronous active-low clear. It is instantiated twice.

## Test plan
- **Load:** after reset, request a load, funct3=010, flag 0 → `memoryMode`=LOAD for 1 cycle, `done`=1 in that cycle, `loadsRetired`=1, back in IDLE with `reqReady`=1.
- **Store:** request a store, funct3=000 → STORE_PRELOAD then STORE on consecutive cycles, `done` in the STORE cycle, `storesRetired`=1.
- **Unaligned store:** request a store, funct3=010, flag 1 during PRELOAD → no STORE cycle, `fault`=1, `faultCause`=UNALIGNED, `reqReady` stays 0 and further `reqValid` is ignored.
- **Illegal funct3:** request a load with funct3=011 → FAULT with cause ILLEGAL_FUNCT3 on the next cycle; `memoryMode` never leaves NOP.
- **Reset during STORE:** assert `reset`=0 in the STORE cycle → `memoryMode`=NOP that cycle, `storesRetired` unchanged at 0, state IDLE afterwards.
- **Counter wrap:** COUNTER_WIDTH=2, five loads → `loadsRetired` sequence 1, 2, 3, 0, 1.
